mux_nto1_pipe: RTL and testbench

MUX_NTO1_PIPE -- requirements
Module: mux_nto1_pipe

---
 rtl/mux_nto1_pipe.sv | 130 +++++++++++++
 tb/tb_mux_nto1_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_pipe.sv
// N-to-1 channel multiplexer with one registered output stage.
// Channels are chosen by explicit select or by round-robin arbitration.
module mux_nto1_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_ch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err
);

  // Every SELW-bit index gets a slot; slots >= N are padding that never grants.
  localparam int unsigned SELN = 1 << SELW;

  logic [SELN-1:0]  chan_exists_c;
  logic [SELN-1:0]  valid_ext_c;
  logic [WIDTH-1:0] chan_data_c [SELN];

  logic [SELW-1:0]  rr_grant_c;
  logic             rr_found_c;
  logic             free_c;
  logic             hit_c;
  logic             grant_c;
  logic             xfer_c;
  logic [SELW-1:0]  ch_c;
  logic [SELN-1:0]  ready_ext_c;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_err_q, sel_err_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

  for (genvar gi = 0; gi < SELN; gi++) begin : g_chan
    if (gi < N) begin : g_real
      assign chan_exists_c[gi] = 1'b1;
      assign valid_ext_c[gi]   = in_valid[gi];
      assign chan_data_c[gi]   = in_data[gi*WIDTH +: WIDTH];
    end else begin : g_pad
      assign chan_exists_c[gi] = 1'b0;
      assign valid_ext_c[gi]   = 1'b0;
      assign chan_data_c[gi]   = '0;
    end
  end

  // Round-robin search: first valid channel at or after rr_ptr, wrapping at N.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    rr_grant_c = '0;
    rr_found_c = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!rr_found_c && valid_ext_c[SELW'(idx)]) begin
        rr_found_c = 1'b1;
        rr_grant_c = SELW'(idx);
      end
    end
  end

  // Channel choice, handshake and select-error detection.
  always_comb begin
    free_c = !out_valid_q || out_ready;
    ch_c   = sel;
    hit_c  = chan_exists_c[sel];
    if (mode) begin
      ch_c  = rr_grant_c;
      hit_c = rr_found_c;
    end
    grant_c     = rst_n && free_c && hit_c;
    ready_ext_c = grant_c ? (SELN'(1) << ch_c) : '0;
    xfer_c      = grant_c && valid_ext_c[ch_c];
    sel_err_d   = rst_n && !mode && !chan_exists_c[sel];
  end

  assign in_ready = ready_ext_c[N-1:0];

  // Output stage next-state: load on transfer, drain when accepted downstream.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer_c) begin
      out_data_d  = chan_data_c[ch_c];
      out_ch_d    = ch_c;
      out_valid_d = 1'b1;
      if (mode) begin
        rr_ptr_d = (ch_c == SELW'(N - 1)) ? '0 : ch_c + SELW'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Bench for mux_nto1_pipe: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_mux_nto1_pipe;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned SW = 2;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, mode, out_ready;
  logic [SW-1:0]   sel;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid, in_ready;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_ch;
  logic            out_valid, sel_err;

  logic            b_mode, b_out_ready;
  logic [1:0]      b_sel;
  logic [3*W-1:0]  b_in_data;
  logic [2:0]      b_in_valid, b_in_ready;
  logic [W-1:0]    b_out_data;
  logic [1:0]      b_out_ch;
  logic            b_out_valid, b_sel_err;

  mux_nto1_pipe #(.WIDTH(W), .N(N), .SELW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err)
  );

  mux_nto1_pipe #(.WIDTH(W), .N(3), .SELW(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(b_mode), .sel(b_sel), .in_data(b_in_data),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data), .out_ch(b_out_ch),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .sel_err(b_sel_err)
  );

  int total;
  int bad;

  // Behavioural model of the 4-channel instance.
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_ch;
  int           m_rr;
  logic         m_err;

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    r = '0;
    if (rst_n && (!m_valid || out_ready)) begin
      if (!mode) begin
        if (int'(sel) < int'(N)) r[sel] = 1'b1;
      end else begin
        for (int k = 0; k < int'(N); k++) begin
          int c;
          c = (m_rr + k) % int'(N);
          if (in_valid[c]) begin
            r[c] = 1'b1;
            break;
          end
        end
      end
    end
    return r;
  endfunction

  // Advance one clock, updating the model from the inputs seen before the edge.
  task automatic step();
    logic [N-1:0] r;
    logic         xfer, n_valid, n_err;
    logic [W-1:0] n_data;
    int           c, n_ch, n_rr;
    r = exp_ready();
    xfer = |(r & in_valid);
    c = 0;
    for (int k = 0; k < int'(N); k++) if (r[k]) c = k;
    n_valid = m_valid; n_data = m_data; n_ch = m_ch; n_rr = m_rr;
    n_err = !mode && (int'(sel) >= int'(N));
    if (!rst_n) begin
      n_valid = 1'b0; n_data = '0; n_ch = 0; n_rr = 0; n_err = 1'b0;
    end else if (xfer) begin
      n_valid = 1'b1; n_data = in_data[c*W +: W]; n_ch = c;
      if (mode) n_rr = (c + 1) % int'(N);
    end else if (out_ready) begin
      n_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    m_valid = n_valid; m_data = n_data; m_ch = n_ch; m_rr = n_rr; m_err = n_err;
  endtask

  task automatic rand_data();
    for (int i = 0; i < int'(N); i++) in_data[i*W +: W] = $urandom;
  endtask

  task automatic test_reset();
    m_valid = 1'b0; m_data = '0; m_ch = 0; m_rr = 0; m_err = 1'b0;
    rst_n = 1'b0; mode = 1'b1; sel = '0; in_valid = '1; out_ready = 1'b1;
    rand_data();
    #1;
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset.in_ready got=%b exp=0000", in_ready); end
    step();
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset.out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset.out_data got=%h exp=0", out_data); end
    total++; if (out_ch !== 2'd0) begin bad++; $display("FAIL reset.out_ch got=%0d exp=0", out_ch); end
    total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL reset.sel_err got=%b exp=0", sel_err); end
  endtask

  task automatic test_explicit();
    rst_n = 1'b1; mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
    rand_data();
    in_data[2*W +: W] = 32'hDEADBEEF;
    #1;
    total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL explicit.in_ready got=%b exp=0100", in_ready); end
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL explicit.out_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 32'hDEADBEEF) begin bad++; $display("FAIL explicit.out_data got=%h exp=deadbeef", out_data); end
    total++; if (out_ch !== 2'd2) begin bad++; $display("FAIL explicit.out_ch got=%0d exp=2", out_ch); end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] exp_d;
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rand_data();
      exp_d = in_data[(k % 4)*W +: W];
      #1;
      total++; if (in_ready !== 4'(1 << (k % 4))) begin bad++; $display("FAIL rr.in_ready[%0d] got=%b exp=%b", k, in_ready, 4'(1 << (k % 4))); end
      step();
      total++; if (out_ch !== 2'(k % 4) || out_valid !== 1'b1 || out_data !== exp_d) begin
        bad++; $display("FAIL rr.out[%0d] got ch=%0d v=%b d=%h exp ch=%0d v=1 d=%h", k, out_ch, out_valid, out_data, k % 4, exp_d);
      end
    end
  endtask

  task automatic test_wrap();
    mode = 1'b1; in_valid = 4'b0100; out_ready = 1'b1;
    rand_data();
    step();
    in_valid = 4'b0010;
    #1;
    total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL wrap.in_ready got=%b exp=0010", in_ready); end
    step();
    total++; if (out_ch !== 2'd1) begin bad++; $display("FAIL wrap.out_ch got=%0d exp=1", out_ch); end
    in_valid = 4'b1111;
    #1;
    total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL wrap.rr_ptr in_ready got=%b exp=0100", in_ready); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] hold_d;
    logic [SW-1:0] hold_c;
    step();
    hold_d = out_data; hold_c = out_ch;
    out_ready = 1'b0; in_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      mode = 1'($urandom); sel = 2'($urandom); rand_data();
      #1;
      total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL hold.in_ready[%0d] got=%b exp=0000", k, in_ready); end
      step();
      total++; if (out_data !== hold_d || out_ch !== hold_c || out_valid !== 1'b1) begin
        bad++; $display("FAIL hold.out[%0d] got d=%h ch=%0d v=%b exp d=%h ch=%0d v=1", k, out_data, out_ch, out_valid, hold_d, hold_c);
      end
    end
    mode = 1'b1; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 4'b1000) begin bad++; $display("FAIL hold.release in_ready got=%b exp=1000", in_ready); end
    hold_d = in_data[3*W +: W];
    step();
    total++; if (out_ch !== 2'd3 || out_data !== hold_d) begin bad++; $display("FAIL hold.release out got ch=%0d d=%h exp ch=3 d=%h", out_ch, out_data, hold_d); end
    in_valid = '0; hold_c = out_ch;
    step();
    total++; if (out_valid !== 1'b0 || out_data !== hold_d || out_ch !== hold_c) begin
      bad++; $display("FAIL drain got v=%b d=%h ch=%0d exp v=0 d=%h ch=%0d", out_valid, out_data, out_ch, hold_d, hold_c);
    end
  endtask

  task automatic test_sel_err();
    in_valid = '0;
    b_mode = 1'b0; b_sel = 2'd3; b_in_valid = 3'b111; b_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) b_in_data[i*W +: W] = $urandom;
    #1;
    total++; if (b_in_ready !== 3'b000) begin bad++; $display("FAIL selerr.in_ready got=%b exp=000", b_in_ready); end
    step();
    total++; if (b_out_valid !== 1'b0 || b_sel_err !== 1'b1) begin bad++; $display("FAIL selerr.pulse got v=%b err=%b exp v=0 err=1", b_out_valid, b_sel_err); end
    b_sel = 2'd1;
    #1;
    total++; if (b_in_ready !== 3'b010) begin bad++; $display("FAIL selerr.recover in_ready got=%b exp=010", b_in_ready); end
    step();
    total++; if (b_sel_err !== 1'b0 || b_out_valid !== 1'b1 || b_out_ch !== 2'd1 || b_out_data !== b_in_data[W +: W]) begin
      bad++; $display("FAIL selerr.after got err=%b v=%b ch=%0d d=%h exp err=0 v=1 ch=1 d=%h", b_sel_err, b_out_valid, b_out_ch, b_out_data, b_in_data[W +: W]);
    end
    b_in_valid = '0;
  endtask

  task automatic test_reset_mid();
    mode = 1'b1; in_valid = 4'b0100; out_ready = 1'b1;
    step();
    out_ready = 1'b0; in_valid = 4'b1111;
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid.setup out_valid got=%b exp=1", out_valid); end
    rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL rstmid.in_ready got=%b exp=0000", in_ready); end
    step();
    total++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_ch !== 2'd0) begin
      bad++; $display("FAIL rstmid.out got v=%b d=%h ch=%0d exp v=0 d=0 ch=0", out_valid, out_data, out_ch);
    end
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL rstmid.first in_ready got=%b exp=0001", in_ready); end
    step();
    total++; if (out_ch !== 2'd0 || out_valid !== 1'b1) begin bad++; $display("FAIL rstmid.first out got ch=%0d v=%b exp ch=0 v=1", out_ch, out_valid); end
  endtask

  task automatic test_random();
    logic [N-1:0] er;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst_n = ($urandom_range(0, 31) != 0);
      mode = 1'($urandom);
      sel = 2'($urandom);
      in_valid = 4'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      rand_data();
      #1;
      er = exp_ready();
      total++; if (in_ready !== er) begin bad++; $display("FAIL random.in_ready[%0d] got=%b exp=%b", cyc, in_ready, er); end
      step();
      total++; if (out_valid !== m_valid || out_data !== m_data || out_ch !== 2'(m_ch) || sel_err !== m_err) begin
        bad++; $display("FAIL random.out[%0d] got v=%b d=%h ch=%0d e=%b exp v=%b d=%h ch=%0d e=%b",
                        cyc, out_valid, out_data, out_ch, sel_err, m_valid, m_data, m_ch, m_err);
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    b_mode = 1'b0; b_sel = '0; b_in_valid = '0; b_out_ready = 1'b1; b_in_data = '0;
    test_reset();
    test_explicit();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_sel_err();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
